// File: rtl/sr_flop.sv
// sr_flop: single-bit set/reset interrupt latch.
// An external event pulses set to raise a sticky interrupt request; the
// processor's acknowledge pulses reset to clear it. rst_sync clears the latch
// during system reset.
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst_sync   synchronous active-high system reset, highest priority
//   reset      synchronous active-high interrupt acknowledge/clear
//   set        synchronous active-high interrupt request
//   interrupt  latch state, driven directly from the flop
module sr_flop (
   input  logic clk,
   input  logic rst_sync,
   input  logic reset,
   input  logic set,
   output logic interrupt
);

   logic q;

   // Set wins over reset so a request arriving during an acknowledge is kept.
   always_ff @(posedge clk) begin
      if (rst_sync) begin
         q <= 1'b0;
      end else if (set) begin
         q <= 1'b1;
      end else if (reset) begin
         q <= 1'b0;
      end
   end

   assign interrupt = q;

endmodule

// File: tb/tb_sr_flop.sv
// tb_sr_flop: self-checking bench for sr_flop.
// Inputs are driven on the falling edge; a reference model pushes the expected
// interrupt value into a scoreboard queue, which each scenario pops and
// compares just after the following rising edge.
module tb_sr_flop;

   logic clk;
   logic rst_sync;
   logic reset;
   logic set;
   logic interrupt;

   logic m_q;
   logic sb[$];
   int   n_cmp;
   int   n_err;

   sr_flop dut (
      .clk       (clk),
      .rst_sync  (rst_sync),
      .reset     (reset),
      .set       (set),
      .interrupt (interrupt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one cycle of stimulus and record the expected post-edge value.
   task automatic drive(input logic s, input logic r, input logic rs);
      @(negedge clk);
      set      = s;
      reset    = r;
      rst_sync = rs;
      if (rs)     m_q = 1'b0;
      else if (s) m_q = 1'b1;
      else if (r) m_q = 1'b0;
      sb.push_back(m_q);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic exp;
      drive(1'b0, 1'b0, 1'b1);
      exp = sb.pop_front();
      n_cmp++;
      if (interrupt !== exp) begin
         n_err++;
         $display("FAIL reset_assert: interrupt=%b expected %b", interrupt, exp);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0);
         exp = sb.pop_front();
         n_cmp++;
         if (interrupt !== exp) begin
            n_err++;
            $display("FAIL reset_idle[%0d]: interrupt=%b expected %b", i, interrupt, exp);
         end
      end
   endtask

   task automatic test_set_pulse();
      logic exp;
      drive(1'b1, 1'b0, 1'b0);
      exp = sb.pop_front();
      n_cmp++;
      if (interrupt !== exp) begin
         n_err++;
         $display("FAIL set_pulse: interrupt=%b expected %b", interrupt, exp);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0);
         exp = sb.pop_front();
         n_cmp++;
         if (interrupt !== exp) begin
            n_err++;
            $display("FAIL set_sticky[%0d]: interrupt=%b expected %b", i, interrupt, exp);
         end
      end
      // Repeated set while already high.
      drive(1'b1, 1'b0, 1'b0);
      exp = sb.pop_front();
      n_cmp++;
      if (interrupt !== exp) begin
         n_err++;
         $display("FAIL set_repeat: interrupt=%b expected %b", interrupt, exp);
      end
   endtask

   task automatic test_clear();
      logic exp;
      drive(1'b0, 1'b1, 1'b0);
      exp = sb.pop_front();
      n_cmp++;
      if (interrupt !== exp) begin
         n_err++;
         $display("FAIL clear: interrupt=%b expected %b", interrupt, exp);
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 1'b0);
         exp = sb.pop_front();
         n_cmp++;
         if (interrupt !== exp) begin
            n_err++;
            $display("FAIL clear_stays[%0d]: interrupt=%b expected %b", i, interrupt, exp);
         end
      end
      // Reset while already low, held for two cycles.
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, 1'b0);
         exp = sb.pop_front();
         n_cmp++;
         if (interrupt !== exp) begin
            n_err++;
            $display("FAIL clear_when_low[%0d]: interrupt=%b expected %b", i, interrupt, exp);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic exp;
      // From low, then again from high.
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, 1'b0);
         exp = sb.pop_front();
         n_cmp++;
         if (interrupt !== exp) begin
            n_err++;
            $display("FAIL simultaneous[%0d]: interrupt=%b expected %b", i, interrupt, exp);
         end
      end
   endtask

   task automatic test_reset_priority();
      logic exp;
      drive(1'b1, 1'b0, 1'b1);
      exp = sb.pop_front();
      n_cmp++;
      if (interrupt !== exp) begin
         n_err++;
         $display("FAIL rst_over_set: interrupt=%b expected %b", interrupt, exp);
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 1'b0);
         exp = sb.pop_front();
         n_cmp++;
         if (interrupt !== exp) begin
            n_err++;
            $display("FAIL rst_release[%0d]: interrupt=%b expected %b", i, interrupt, exp);
         end
      end
      // rst_sync with set and reset both high still clears.
      drive(1'b1, 1'b0, 1'b0);
      void'(sb.pop_front());
      drive(1'b1, 1'b1, 1'b1);
      exp = sb.pop_front();
      n_cmp++;
      if (interrupt !== exp) begin
         n_err++;
         $display("FAIL rst_over_all: interrupt=%b expected %b", interrupt, exp);
      end
   endtask

   task automatic test_hold();
      logic exp;
      for (int st = 0; st < 2; st++) begin
         drive(st == 1, 1'b0, 1'b0);
         void'(sb.pop_front());
         for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            exp = sb.pop_front();
            n_cmp++;
            if (interrupt !== exp) begin
               n_err++;
               $display("FAIL hold_s%0d[%0d]: interrupt=%b expected %b", st, i, interrupt, exp);
            end
         end
      end
   endtask

   task automatic test_random();
      logic exp;
      logic [2:0] r;
      for (int i = 0; i < 200; i++) begin
         r = 3'($urandom_range(0, 7));
         // Keep rst_sync rare so the latch spends time in both states.
         drive(r[0], r[1], r[2] && ($urandom_range(0, 3) == 0));
         exp = sb.pop_front();
         n_cmp++;
         if (interrupt !== exp) begin
            n_err++;
            $display("FAIL random[%0d]: interrupt=%b expected %b", i, interrupt, exp);
         end
      end
   endtask

   initial begin
      set      = 1'b0;
      reset    = 1'b0;
      rst_sync = 1'b0;
      m_q      = 1'bx;
      n_cmp    = 0;
      n_err    = 0;
      test_reset();
      test_set_pulse();
      test_clear();
      test_simultaneous();
      test_reset_priority();
      test_hold();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
